icap_cfg_seq: RTL



---
 rtl/icap_cfg_seq_pkg.sv | 33 +++
 rtl/icap_cfg_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/icap_cfg_seq_pkg.sv
// icap_cfg_pkg: shared types and constants for the ICAPE2 configuration
// sequencer (icap_cfg_seq).
//   state_t      sequencer states
//   DUMMY..DES1  fixed script words of the configuration frame
//   HDR_*        type-1 header bases and the register-address shift
//   bitrev8x4    per-byte bit reversal used on the ICAP data buses
package icap_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE, PRE, WDAT, RTURN, RWAIT, RBACK, POST, DONE
  } state_t;

  localparam logic [31:0] DUMMY = 32'hFFFF_FFFF;
  localparam logic [31:0] SYNC  = 32'hAA99_5566;
  localparam logic [31:0] NOOP  = 32'h2000_0000;
  localparam logic [31:0] DES0  = 32'h3000_8001;  // write CMD register
  localparam logic [31:0] DES1  = 32'h0000_000D;  // DESYNC command

  localparam logic [31:0] HDR_WR_BASE = 32'h3000_0001;
  localparam logic [31:0] HDR_RD_BASE = 32'h2800_0001;
  localparam int          HDR_ADDR_SH = 13;

  // ICAPE2 expects bit 0 of each byte on the MSB of that byte lane.
  function automatic logic [31:0] bitrev8x4(input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 8; k++)
        r[8*b + k] = w[8*b + 7 - k];
    return r;
  endfunction

endpackage

// File: rtl/icap_cfg_seq.sv
// icap_cfg_seq: drives an ICAPE2 (32-bit) through a complete configuration
// frame for one register read or write per request.
//
// Build option: define ICAP_CFG_SEQ_READ_EN to include the readback path.
// Without it, read requests are rejected with an err pulse, rdata is 0 and
// icap_rdwrb is held at 0.
//
// Ports:
//   clk, rst_n         clock (also ICAPE2 CLK), async active-low reset
//   req_valid/ready    request handshake; ready only in IDLE after START_DLY
//   req_wr/addr/wdata  1=write/0=read, config register address, write data
//   done               one-cycle pulse at end of operation
//   rdata              read result, held until the next read completes
//   err                one-cycle pulse when a request is rejected
//   icap_csib/rdwrb/i  registered drives to the ICAPE2
//   icap_o             ICAPE2 readback data
module icap_cfg_seq
  import icap_cfg_pkg::*;
#(
  parameter int START_DLY = 2048,
  parameter int READ_LAT  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        icap_csib,
  output logic        icap_rdwrb,
  output logic [31:0] icap_i,
  input  logic [31:0] icap_o
);

  localparam int CW = (START_DLY > 1) ? $clog2(START_DLY) : 1;

  logic [CW-1:0] dly_cnt;
  logic          start_done;
  state_t        state;
  logic [3:0]    idx;
  logic          wr_q;
  logic [4:0]    addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   hdr;
  logic [31:0]   word;
  logic          accept;
  logic          pre_last;

  assign start_done = (dly_cnt == CW'(START_DLY - 1));
  assign accept     = req_valid && req_ready;
  assign hdr        = (wr_q ? HDR_WR_BASE : HDR_RD_BASE) | (32'(addr_q) << HDR_ADDR_SH);
  // A read carries two extra NOOPs after the header before bus turnaround.
  assign pre_last   = wr_q ? (idx == 4'd4) : (idx == 4'd6);

  // Start-delay counter: saturates, restarts only on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           dly_cnt <= '0;
    else if (!start_done) dly_cnt <= dly_cnt + 1'b1;
  end

  // Script word for the current state/index; registered by the FSM below,
  // so the bus trails the state by one cycle.
  always_comb begin
    word = NOOP;
    case (state)
      PRE: begin
        case (idx)
          4'd0:    word = DUMMY;
          4'd1:    word = SYNC;
          4'd4:    word = hdr;
          default: word = NOOP;
        endcase
      end
      WDAT:    if (idx == 4'd0) word = wdata_q;
      POST: begin
        case (idx)
          4'd0:    word = DES0;
          4'd1:    word = DES1;
          default: word = NOOP;
        endcase
      end
      default: word = NOOP;
    endcase
  end

`ifndef ICAP_CFG_SEQ_READ_EN
  logic unused_rd;
  assign unused_rd  = ^{icap_o, 4'(READ_LAT)};
  assign rdata      = '0;
  assign icap_rdwrb = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      req_ready  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      icap_csib  <= 1'b1;
      icap_i     <= '0;
`ifdef ICAP_CFG_SEQ_READ_EN
      icap_rdwrb <= 1'b0;
      rdata      <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          icap_csib <= 1'b1;
          icap_i    <= '0;
          idx       <= '0;
`ifdef ICAP_CFG_SEQ_READ_EN
          icap_rdwrb <= 1'b0;
`endif
          if (accept) begin
            req_ready <= 1'b0;
            wr_q      <= req_wr;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
`ifdef ICAP_CFG_SEQ_READ_EN
            state     <= PRE;
`else
            // Reads are not built in: reject, stay idle, reopen next cycle.
            if (req_wr) state <= PRE;
            else        err   <= 1'b1;
`endif
          end else begin
            req_ready <= start_done;
          end
        end
        PRE: begin
          icap_csib <= 1'b0;
          icap_i    <= bitrev8x4(word);
          if (pre_last) begin
            idx   <= '0;
            state <= wr_q ? WDAT : RTURN;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        WDAT: begin
          icap_csib <= 1'b0;
          icap_i    <= bitrev8x4(word);
          if (idx == 4'd2) begin
            idx   <= '0;
            state <= POST;
          end else begin
            idx <= idx + 4'd1;
          end
        end
`ifdef ICAP_CFG_SEQ_READ_EN
        RTURN: begin
          // Deselect while flipping direction.
          icap_csib  <= 1'b1;
          icap_rdwrb <= 1'b1;
          icap_i     <= '0;
          idx        <= '0;
          state      <= RWAIT;
        end
        RWAIT: begin
          icap_csib <= 1'b0;
          icap_i    <= '0;
          if (idx == 4'(READ_LAT - 1)) begin
            idx   <= '0;
            state <= RBACK;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        RBACK: begin
          icap_csib <= 1'b1;
          icap_i    <= '0;
          if (idx == 4'd0) begin
            // This edge closes the last CSIB-low read cycle.
            rdata <= bitrev8x4(icap_o);
            idx   <= 4'd1;
          end else begin
            icap_rdwrb <= 1'b0;
            idx        <= '0;
            state      <= POST;
          end
        end
`endif
        POST: begin
          icap_csib <= 1'b0;
          icap_i    <= bitrev8x4(word);
          if (idx == 4'd3) begin
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        DONE: begin
          icap_csib <= 1'b1;
          icap_i    <= '0;
          done      <= 1'b1;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
